// File: rtl/lsu_mem_if.sv
// Data-memory request/response bus between the load/store unit (master) and memory (slave).
interface lsu_mem_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: stalls the core while a multi-cycle data-memory access runs, then retires it.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of truncating them.
module lsu_mem_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Load,
    input  logic              Store,
    input  logic [2:0]        fun3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              done,
    output logic              bus_err,
    lsu_mem_if.master         mem
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic              is_load_q, is_load_d;
    logic [2:0]        fun3_q, fun3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [31:0]       ld_q, ld_d;
    logic              err_q, err_d;

    // Size decode: 00 byte, 01 half, anything else is a word access.
    logic       in_byte, in_half;
    logic [3:0] in_wmask;
    logic [31:0] in_wdata;

    always_comb begin
        in_byte = (fun3[1:0] == 2'b00);
        in_half = (fun3[1:0] == 2'b01);
        if (in_byte) begin
            in_wmask = 4'b0001 << addr[1:0];
            in_wdata = {4{store_data[7:0]}};
        end else if (in_half) begin
            in_wmask = addr[1] ? 4'b1100 : 4'b0011;
            in_wdata = {2{store_data[15:0]}};
        end else begin
            in_wmask = 4'b1111;
            in_wdata = store_data;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = (in_half & addr[0]) | (~in_byte & ~in_half & (addr[1:0] != 2'b00));
`endif

    // Lane extraction and sign/zero extension of the returned word.
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    always_comb begin
        unique case (addr_q[1:0])
            2'b00:   rd_byte = mem.mem_rdata[7:0];
            2'b01:   rd_byte = mem.mem_rdata[15:8];
            2'b10:   rd_byte = mem.mem_rdata[23:16];
            default: rd_byte = mem.mem_rdata[31:24];
        endcase
        rd_half = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        if (fun3_q[1:0] == 2'b00) begin
            rd_ext = fun3_q[2] ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
        end else if (fun3_q[1:0] == 2'b01) begin
            rd_ext = fun3_q[2] ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
        end else begin
            rd_ext = mem.mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            is_load_q <= 1'b0;
            fun3_q    <= 3'd0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            wmask_q   <= 4'd0;
            cnt_q     <= 8'd0;
            ld_q      <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
            fun3_q    <= fun3_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            cnt_q     <= cnt_d;
            ld_q      <= ld_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        is_load_d = is_load_q;
        fun3_d    = fun3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        cnt_d     = cnt_q;
        ld_d      = ld_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                if (Load | Store) begin
                    is_load_d = Load;
                    fun3_d    = fun3;
                    addr_d    = addr;
                    wdata_d   = in_wdata;
                    wmask_d   = in_wmask;
                    ld_d      = 32'd0;
                    err_d     = 1'b0;
                    state_d   = StReq;
`ifdef MISALIGN_TRAP_EN
                    if (misalign) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
`endif
                end
            end
            StReq: begin
                if (mem.mem_ready) begin
                    cnt_d   = 8'd0;
                    state_d = is_load_q ? StWait : StDone;
                end
            end
            StWait: begin
                if (mem.mem_rvalid) begin
                    ld_d    = rd_ext;
                    state_d = StDone;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    ld_d    = 32'd0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall         = 1'b0;
        done          = 1'b0;
        bus_err       = 1'b0;
        load_data     = 32'd0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = 32'd0;
        mem.mem_wmask = 4'd0;
        unique case (state_q)
            StIdle: stall = Load | Store;
            StReq: begin
                stall         = 1'b1;
                mem.mem_req   = 1'b1;
                mem.mem_we    = ~is_load_q;
                mem.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                mem.mem_wdata = is_load_q ? 32'd0 : wdata_q;
                mem.mem_wmask = is_load_q ? 4'd0 : wmask_q;
            end
            StWait: stall = 1'b1;
            StDone: begin
                done      = 1'b1;
                bus_err   = err_q;
                load_data = ld_q;
            end
            default: stall = 1'b0;
        endcase
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit: the memory-side responder to the decoder's Load/Store/fun3 controls.
- Takes the effective address (ALU result) and rs2 store data from the datapath.
- Runs a multi-cycle request/response handshake with data memory.
- Stalls the single-cycle core until the access retires; returns sign/zero-extended load data to writeback.

Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT, 16, max cycles in WAIT for mem_rvalid before bus error (range 2..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Load  in  1  load instruction present.
- Store  in  1  store instruction present.
- fun3  in  3  access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu, 110 treated as w).
- addr  in  ADDR_W  effective byte address.
- store_data  in  32  rs2 value.
- stall  out  1  freeze PC/regfile.
- load_data  out  32  extended load result, valid while done=1.
- done  out  1  one-cycle retire pulse.
- bus_err  out  1  one-cycle pulse with done on timeout or misalign trap.
- mem_req  out  1  request valid.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  word-aligned address (addr[1:0] forced 00).
- mem_wdata  out  32  lane-replicated write data.
- mem_wmask  out  4  byte enables.
- mem_ready  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - All outputs 0; state IDLE; timeout counter 0.
  - Reset mid-access abandons it; mem_req drops at the reset edge.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - stall = Load|Store (combinational).
  - On Load|Store, register addr, fun3, store_data and kind, then go to REQ. Load has priority if both are set.
- REQ:
  - mem_req=1; mem_we=Store; addr/wdata/wmask held stable until accepted.
  - On mem_ready: store goes to DONE; load goes to WAIT with counter cleared.
- WAIT:
  - mem_rvalid is ignored in the acceptance cycle.
  - On mem_rvalid: capture mem_rdata and go to DONE.
  - Otherwise the counter increments; at counter==TIMEOUT-1, go to DONE with bus_err=1 and load_data=0.
- DONE:
  - stall=0, done=1 for exactly one cycle, then IDLE.
  - The next instruction is sampled in IDLE on the following cycle, so there is no re-trigger of the same instruction.
- Latency: store retires minimum 2 cycles after entry (IDLE→REQ→DONE); load minimum 3 (IDLE→REQ→WAIT→DONE).
- Store lanes, o = addr[1:0]:
  - sb: wmask = 0001<<o, wdata = {4{byte}}.
  - sh: wmask = 0011 if addr[1]=0, else 1100; wdata = {2{half}}.
  - sw: wmask = 1111.
- Load extract:
  - lb/lbu take byte o.
  - lh/lhu take half addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; w passes the word.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]≠00.
  - Without the feature, low bits are truncated to natural alignment and the access proceeds.
- Unsupported fun3 (011, 111): treated as word.

Optional Feature:
- MISALIGN_TRAP_EN defined: misaligned access goes IDLE→DONE directly, with no mem_req, bus_err=1, load_data=0, and no memory write.
- MISALIGN_TRAP_EN undefined: truncation behaviour as above; bus_err only on timeout.

Test Plan:
- Reset: rst=1 during REQ → next cycle mem_req=0, stall=0, done=0, state IDLE.
- sb: addr=0x1003, store_data=0x000000A5, mem_ready immediate → mem_addr=0x1000, wmask=1000, wdata=0xA5A5A5A5; done 2 cycles after entry.
- lb/lbu: mem_rdata=0x80FF7F01, addr offset 2 → lb gives 0xFFFFFFFF; lbu gives 0x000000FF; lh at offset 2 gives 0xFFFF80FF.
- Backpressure: mem_ready low 3 cycles, then rvalid 2 cycles after accept → stall high throughout, req/addr stable, single done pulse, load_data=rdata.
- Timeout: TIMEOUT=16, rvalid never arrives → done+bus_err exactly 16 cycles after entering WAIT, load_data=0.
- Misalign: lw at addr=0x2002 → with MISALIGN_TRAP_EN, no mem_req and bus_err pulse; without, mem_addr=0x2000 and normal word load.
